// File: rtl/alu_if.sv
// Operand/opcode and registered result/flag bundle between the operand stage and the ALU.
// The master drives the operation; the slave (the ALU) returns the result and flags.
interface alu_if;
   logic [7:0] input_a;
   logic [7:0] input_b;
   logic [3:0] opcode;
   logic [7:0] ALU_result;
   logic       flag_z;
   logic       flag_n;
   logic       flag_c;
   logic       flag_v;

   modport master (
      output input_a, input_b, opcode,
      input  ALU_result, flag_z, flag_n, flag_c, flag_v
   );

   modport slave (
      input  input_a, input_b, opcode,
      output ALU_result, flag_z, flag_n, flag_c, flag_v
   );
endinterface

// File: rtl/alu.sv
// Eight-bit ALU execute stage: combinational datapath feeding a single register stage
// for the result and the Z/N/C/V condition codes.
module alu (
   input logic  clock,
   input logic  reset_n,
   alu_if.slave bus
);
   typedef enum logic [3:0] {
      OpAnd  = 4'h0, OpOr  = 4'h1, OpNot = 4'h2, OpNeg = 4'h3,
      OpAdd  = 4'h4, OpSub = 4'h5, OpXor = 4'h6, OpMul = 4'h7,
      OpShl  = 4'h8, OpShr = 4'h9, OpShra = 4'hA, OpRol = 4'hB,
      OpRor  = 4'hC, OpInc = 4'hD, OpDec = 4'hE, OpPass = 4'hF
   } op_e;

   logic [7:0]        a, b;
   logic [2:0]        s;
   op_e               op;
   logic [8:0]        sum;
   logic [15:0]       prod;
   logic [8:0]        shl;
   logic [8:0]        shr;
   logic signed [8:0] shra;
   logic [15:0]       dbl;
   logic [7:0]        result_d, result_q;
   logic              c_d, v_d;
   logic              z_q, n_q, c_q, v_q;

   always_comb begin
      a        = bus.input_a;
      b        = bus.input_b;
      s        = bus.input_b[2:0];
      op       = op_e'(bus.opcode);
      sum      = 9'h000;
      prod     = 16'h0000;
      shl      = 9'h000;
      shr      = 9'h000;
      shra     = 9'sh000;
      dbl      = 16'h0000;
      result_d = 8'h00;
      c_d      = 1'b0;
      v_d      = 1'b0;
      unique case (op)
         OpAnd: result_d = a & b;
         OpOr:  result_d = a | b;
         OpNot: result_d = ~a;
         OpNeg: begin
            sum      = {1'b0, ~a} + 9'd1;
            result_d = sum[7:0];
            c_d      = (a != 8'h00);
            v_d      = (a == 8'h80);
         end
         OpAdd: begin
            sum      = {1'b0, a} + {1'b0, b};
            result_d = sum[7:0];
            c_d      = sum[8];
            v_d      = (a[7] == b[7]) && (result_d[7] != a[7]);
         end
         // Ninth bit of a 9-bit difference is the unsigned borrow.
         OpSub: begin
            sum      = {1'b0, a} - {1'b0, b};
            result_d = sum[7:0];
            c_d      = sum[8];
            v_d      = (a[7] != b[7]) && (result_d[7] != a[7]);
         end
         OpXor: result_d = a ^ b;
         OpMul: begin
            prod     = {8'h00, a} * {8'h00, b};
            result_d = prod[7:0];
            c_d      = (prod[15:8] != 8'h00);
         end
         // One guard bit catches the last bit shifted out; it stays 0 when s = 0.
         OpShl: begin
            shl      = {1'b0, a} << s;
            result_d = shl[7:0];
            c_d      = shl[8];
         end
         OpShr: begin
            shr      = {a, 1'b0} >> s;
            result_d = shr[8:1];
            c_d      = shr[0];
         end
         OpShra: begin
            shra     = $signed({a, 1'b0}) >>> s;
            result_d = shra[8:1];
            c_d      = shra[0];
         end
         OpRol: begin
            dbl      = {a, a} << s;
            result_d = dbl[15:8];
            c_d      = (s != 3'd0) && result_d[0];
         end
         OpRor: begin
            dbl      = {a, a} >> s;
            result_d = dbl[7:0];
            c_d      = (s != 3'd0) && result_d[7];
         end
         OpInc: begin
            sum      = {1'b0, a} + 9'd1;
            result_d = sum[7:0];
            c_d      = sum[8];
            v_d      = !a[7] && result_d[7];
         end
         OpDec: begin
            sum      = {1'b0, a} - 9'd1;
            result_d = sum[7:0];
            c_d      = sum[8];
            v_d      = a[7] && !result_d[7];
         end
         OpPass: result_d = b;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         result_q <= 8'h00;
         z_q      <= 1'b1;
         n_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
      end else begin
         result_q <= result_d;
         z_q      <= (result_d == 8'h00);
         n_q      <= result_d[7];
         c_q      <= c_d;
         v_q      <= v_d;
      end
   end

   assign bus.ALU_result = result_q;
   assign bus.flag_z     = z_q;
   assign bus.flag_n     = n_q;
   assign bus.flag_c     = c_q;
   assign bus.flag_v     = v_q;
endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed corner cases, then back-to-back random operations
// checked against an integer-arithmetic reference model.
module tb_alu;
   logic clock = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [7:0] prev_r;
   logic [3:0] prev_f;
   logic [3:0] dut_f;

   alu_if bus ();

   alu dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   assign dut_f = {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic; flags packed as {Z, N, C, V}.
   function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic [3:0] f);
      int   ua, ub, sa, sb, full, x, s;
      logic c, v;
      ua   = int'(a);
      ub   = int'(b);
      sa   = (ua >= 128) ? ua - 256 : ua;
      sb   = (ub >= 128) ? ub - 256 : ub;
      s    = ub % 8;
      x    = ua;
      full = 0;
      c    = 1'b0;
      v    = 1'b0;
      case (op)
         4'h0: full = ua & ub;
         4'h1: full = ua | ub;
         4'h2: full = 255 - ua;
         4'h3: begin full = 256 - ua; c = (ua != 0); v = (ua == 128); end
         4'h4: begin full = ua + ub; c = (full > 255); v = (sa + sb > 127) || (sa + sb < -128); end
         4'h5: begin full = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
         4'h6: full = ua ^ ub;
         4'h7: begin full = ua * ub; c = (full > 255); end
         4'h8: begin
            for (int k = 0; k < s; k++) begin c = (x >= 128); x = (x * 2) % 256; end
            full = x;
         end
         4'h9: begin
            for (int k = 0; k < s; k++) begin c = (x % 2 == 1); x = x / 2; end
            full = x;
         end
         4'hA: begin
            for (int k = 0; k < s; k++) begin
               c = (x % 2 == 1);
               x = (x >= 128) ? x / 2 + 128 : x / 2;
            end
            full = x;
         end
         4'hB: begin
            for (int k = 0; k < s; k++) begin c = (x >= 128); x = (x * 2) % 256 + (c ? 1 : 0); end
            full = x;
         end
         4'hC: begin
            for (int k = 0; k < s; k++) begin c = (x % 2 == 1); x = x / 2 + (c ? 128 : 0); end
            full = x;
         end
         4'hD: begin full = ua + 1; c = (full > 255); v = (sa + 1 > 127); end
         4'hE: begin full = ua - 1; c = (ua < 1); v = (sa - 1 < -128); end
         4'hF: full = ub;
      endcase
      r = 8'(((full % 256) + 256) % 256);
      f = {r == 8'h00, r >= 8'h80, c, v};
   endfunction

   task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      bus.opcode  = op;
      bus.input_a = a;
      bus.input_b = b;
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] r_exp, input logic [3:0] f_exp);
      @(negedge clock);
      drive(op, a, b);
      @(posedge clock);
      #1;
      check({tag, ".res"}, bus.ALU_result, r_exp);
      check({tag, ".zncv"}, {4'h0, dut_f}, {4'h0, f_exp});
   endtask

   initial begin
      logic [3:0] op, ef;
      logic [7:0] a, b, er;
      int start;

      reset_n = 1'b0;
      drive(4'h1, 8'd15, 8'd3);
      for (int i = 0; i < 2; i++) begin
         @(posedge clock);
         #1;
         check($sformatf("reset%0d.res", i), bus.ALU_result, 8'h00);
         check($sformatf("reset%0d.zncv", i), {4'h0, dut_f}, 8'h08);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check("or_after_reset.res", bus.ALU_result, 8'h0F);
      check("or_after_reset.zncv", {4'h0, dut_f}, 8'h00);
      // A reset pulse between edges must not disturb the registered outputs.
      #1 reset_n = 1'b0;
      #1 reset_n = 1'b1;
      check("midcycle_reset.res", bus.ALU_result, 8'h0F);

      run_op("and",      4'h0, 8'd15, 8'd3,  8'h03, 4'b0000);
      run_op("or",       4'h1, 8'd15, 8'd3,  8'h0F, 4'b0000);
      run_op("not",      4'h2, 8'd15, 8'd3,  8'hF0, 4'b0100);
      run_op("neg",      4'h3, 8'd15, 8'd3,  8'hF1, 4'b0110);
      run_op("add_ovf",  4'h4, 8'h7F, 8'h01, 8'h80, 4'b0101);
      run_op("add_cry",  4'h4, 8'hFF, 8'h01, 8'h00, 4'b1010);
      run_op("sub_brw",  4'h5, 8'h00, 8'h01, 8'hFF, 4'b0110);
      run_op("neg_80",   4'h3, 8'h80, 8'h00, 8'h80, 4'b0111);
      run_op("neg_00",   4'h3, 8'h00, 8'h00, 8'h00, 4'b1000);
      run_op("shl1",     4'h8, 8'h81, 8'h01, 8'h02, 4'b0010);
      run_op("shr1",     4'h9, 8'h81, 8'h01, 8'h40, 4'b0010);
      run_op("shra1",    4'hA, 8'h81, 8'h01, 8'hC0, 4'b0110);
      run_op("rol1",     4'hB, 8'h81, 8'h01, 8'h03, 4'b0010);
      run_op("ror1",     4'hC, 8'h81, 8'h01, 8'hC0, 4'b0110);
      run_op("shl_s0",   4'h8, 8'h81, 8'h08, 8'h81, 4'b0100);
      run_op("ror_s0",   4'hC, 8'h81, 8'h08, 8'h81, 4'b0100);
      run_op("mul_hi",   4'h7, 8'h10, 8'h10, 8'h00, 4'b1010);
      run_op("mul_lo",   4'h7, 8'd15, 8'd3,  8'h2D, 4'b0000);
      run_op("inc_ff",   4'hD, 8'hFF, 8'h00, 8'h00, 4'b1010);
      run_op("dec_80",   4'hE, 8'h80, 8'h00, 8'h7F, 4'b0001);
      run_op("pass",     4'hF, 8'h00, 8'hA5, 8'hA5, 4'b0100);
      prev_r = 8'hA5;
      prev_f = 4'b0100;

      // First 16 cycles cover every opcode once; the rest are fully random.
      start = int'($urandom_range(0, 15));
      for (int i = 0; i < 216; i++) begin
         @(negedge clock);
         op = (i < 16) ? 4'((start + 7 * i) % 16) : 4'($urandom_range(0, 15));
         a  = 8'($urandom);
         b  = 8'($urandom);
         drive(op, a, b);
         reset_n = (i != 9) && (i != 100);
         #1;
         check($sformatf("hold%0d.res", i), bus.ALU_result, prev_r);
         check($sformatf("hold%0d.zncv", i), {4'h0, dut_f}, {4'h0, prev_f});
         if (reset_n) begin
            model(op, a, b, er, ef);
         end else begin
            er = 8'h00;
            ef = 4'b1000;
         end
         @(posedge clock);
         #1;
         check($sformatf("b2b%0d.op%0h.res", i, op), bus.ALU_result, er);
         check($sformatf("b2b%0d.op%0h.zncv", i, op), {4'h0, dut_f}, {4'h0, ef});
         prev_r = er;
         prev_f = ef;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
